// File: rtl/filter_output_arbiter_pkg.sv
// Shared widths for the force-evaluation unit, plus the filter-bank sizing
// used by the filter output arbiter.
package MD_pkg;
  localparam int PARTICLE_ID_WIDTH    = 16;
  localparam int POS_PKT_STRUCT_WIDTH = 48;
  localparam int NODE_ID_WIDTH        = 8;
  localparam int NUM_FILTER           = 8;
  localparam int FILTER_ID_WIDTH      = $clog2(NUM_FILTER);

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0]    parid;
    logic [POS_PKT_STRUCT_WIDTH-1:0] nb_pkt;
    logic [NODE_ID_WIDTH-1:0]        node_id;
  } pair_t;
endpackage

// File: rtl/filter_output_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_priority_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);
  logic         found;
  logic [W-1:0] cand;

  // N is a power of two, so the W-bit add wraps modulo N for free
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr_i + W'(k);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end
endmodule

// File: rtl/filter_output_arbiter.sv
// Round-robin arbiter sharing the force-pipeline input among the filter bank;
// empty-buffer reads are counted as neighbor releases instead of forwarded.
module filter_output_arbiter #(
  parameter int NUM_FILTER      = MD_pkg::NUM_FILTER,
  parameter int FILTER_ID_WIDTH = $clog2(NUM_FILTER)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_FILTER-1:0]                             i_filter_request,
  input  logic [NUM_FILTER*MD_pkg::PARTICLE_ID_WIDTH-1:0]   i_buffer_rd_data,
  input  logic [NUM_FILTER-1:0]                             i_buffer_rd_data_valid,
  input  logic [NUM_FILTER*MD_pkg::POS_PKT_STRUCT_WIDTH-1:0] i_nb_reg,
  input  logic [NUM_FILTER*MD_pkg::NODE_ID_WIDTH-1:0]       i_node_id_reg,
  input  logic                                              i_force_ready,
  output logic [NUM_FILTER-1:0]                             o_buffer_rd_en,
  output logic                                              o_pair_valid,
  output logic [MD_pkg::PARTICLE_ID_WIDTH-1:0]              o_home_parid,
  output logic [MD_pkg::POS_PKT_STRUCT_WIDTH-1:0]           o_nb_pkt,
  output logic [MD_pkg::NODE_ID_WIDTH-1:0]                  o_nb_node_id,
  output logic [FILTER_ID_WIDTH-1:0]                        o_filter_sel,
  output logic [31:0]                                       o_release_cnt,
  output logic                                              o_idle
);
  import MD_pkg::*;

  localparam int PW = PARTICLE_ID_WIDTH;
  localparam int NW = POS_PKT_STRUCT_WIDTH;
  localparam int DW = NODE_ID_WIDTH;
  localparam int FW = FILTER_ID_WIDTH;

  logic [NUM_FILTER-1:0] mask_q, elig, gnt;
  logic [FW-1:0]         rr_ptr_q, gnt_idx, sel_d1_q;
  logic                  vld_d1_q, grant;

  pair_t         pair_q, pair_d;
  logic          pv_q, pv_d;
  logic [FW-1:0] sel_q, sel_d;
  logic [31:0]   rel_q, rel_d;

  // The empty flag lags the read by a cycle, so last cycle's grantee sits out
  assign elig  = i_filter_request & ~mask_q;
  assign grant = !rst && i_force_ready && (|elig);

  rr_priority_arbiter #(.N(NUM_FILTER), .W(FW)) u_arb (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign o_buffer_rd_en = grant ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q   <= '0;
      rr_ptr_q <= '0;
      vld_d1_q <= 1'b0;
      sel_d1_q <= '0;
    end else begin
      mask_q   <= o_buffer_rd_en;
      vld_d1_q <= grant;
      if (grant) begin
        sel_d1_q <= gnt_idx;
        rr_ptr_q <= gnt_idx + 1'b1;
      end
    end
  end

  // Neighbor packet must be taken now; the filter may load the next one a cycle later
  always_comb begin
    pv_d   = 1'b0;
    pair_d = pair_q;
    sel_d  = sel_q;
    rel_d  = rel_q;
    if (vld_d1_q) begin
      if (i_buffer_rd_data_valid[sel_d1_q]) begin
        pv_d           = 1'b1;
        pair_d.parid   = i_buffer_rd_data[int'(sel_d1_q)*PW +: PW];
        pair_d.nb_pkt  = i_nb_reg[int'(sel_d1_q)*NW +: NW];
        pair_d.node_id = i_node_id_reg[int'(sel_d1_q)*DW +: DW];
        sel_d          = sel_d1_q;
      end else if (rel_q != 32'hFFFF_FFFF) begin
        rel_d = rel_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q   <= 1'b0;
      pair_q <= '0;
      sel_q  <= '0;
      rel_q  <= '0;
    end else begin
      pv_q   <= pv_d;
      pair_q <= pair_d;
      sel_q  <= sel_d;
      rel_q  <= rel_d;
    end
  end

  assign o_pair_valid  = pv_q;
  assign o_home_parid  = pair_q.parid;
  assign o_nb_pkt      = pair_q.nb_pkt;
  assign o_nb_node_id  = pair_q.node_id;
  assign o_filter_sel  = sel_q;
  assign o_release_cnt = rel_q;
  assign o_idle        = rst || (!(|i_filter_request) && !vld_d1_q && !pv_q);
endmodule
